// File: rtl/ivmul_pkg.sv
// ivmul_pkg: shared opcodes and request/response bundles
// for the shared SIMD multiplier and its two-port arbiter.
package ivmul_pkg;

   localparam int IVMUL_TAG_W = 6;

   localparam logic [1:0] IVMUL_LO  = 2'b00;
   localparam logic [1:0] IVMUL_HI  = 2'b01;
   localparam logic [1:0] IVMUL_DOT = 2'b10;
   localparam logic [1:0] IVMUL_ILL = 2'b11;

   typedef struct packed {
      logic [31:0]            a;
      logic [31:0]            b;
      logic [1:0]             opc;
      logic [IVMUL_TAG_W-1:0] tag;
   } ivmul_req_t;

   typedef struct packed {
      logic [31:0]            result;
      logic                   port;
      logic [IVMUL_TAG_W-1:0] tag;
      logic                   illegal;
   } ivmul_rsp_t;

endpackage

// File: rtl/ivmul_arbiter_if.sv
// ivmul_arbiter_if: two request ports (valid/ready, a, b, opc, tag)
// and one response port (valid/ready, result, port, tag, illegal).
interface ivmul_arbiter_if #(
   parameter int TAG_W = 6
);

   logic [1:0]            req_valid_i;
   logic [1:0]            req_ready_o;
   logic [1:0][31:0]      req_a_i;
   logic [1:0][31:0]      req_b_i;
   logic [1:0][1:0]       req_opc_i;
   logic [1:0][TAG_W-1:0] req_tag_i;

   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [31:0]           rsp_result_o;
   logic                  rsp_port_o;
   logic [TAG_W-1:0]      rsp_tag_o;
   logic                  rsp_illegal_o;

   modport slave (
      input  req_valid_i, req_a_i, req_b_i,
      input  req_opc_i, req_tag_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_result_o,
      output rsp_port_o, rsp_tag_o, rsp_illegal_o
   );

   modport master (
      output req_valid_i, req_a_i, req_b_i,
      output req_opc_i, req_tag_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o,
      input  rsp_port_o, rsp_tag_o, rsp_illegal_o
   );

endinterface

// File: rtl/ivmul.sv
// ivmul: combinational packed 2x16 signed multiplier.
// Ports: a, b operands, opc select, result.
module ivmul
   import ivmul_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  opc,
   output logic [31:0] result
);

   logic signed [31:0] a0, a1, b0, b1;
   logic signed [31:0] p0, p1;

   assign a0 = {{16{a[15]}}, a[15:0]};
   assign a1 = {{16{a[31]}}, a[31:16]};
   assign b0 = {{16{b[15]}}, b[15:0]};
   assign b1 = {{16{b[31]}}, b[31:16]};

   // 16x16 signed always fits in 32 bits.
   assign p0 = a0 * b0;
   assign p1 = a1 * b1;

   always_comb begin
      result = p0;
      unique case (opc)
         IVMUL_LO:  result = {p1[15:0], p0[15:0]};
         IVMUL_HI:  result = {p1[31:16], p0[31:16]};
         IVMUL_DOT: result = p0 + p1;
         default:   result = p0;
      endcase
   end

endmodule

// File: rtl/ivmul_arbiter.sv
// ivmul_arbiter: round-robin share of one ivmul between two ports,
// S1 operand register, S2 result register, flush, full backpressure.
module ivmul_arbiter
   import ivmul_pkg::*;
#(
   parameter int TAG_W = IVMUL_TAG_W
) (
   input  logic            core_clock_i,
   input  logic            core_reset_n_i,
   input  logic            flush_i,
   ivmul_arbiter_if.slave  bus
);

   if (TAG_W != IVMUL_TAG_W) begin : g_tag_chk
      $error("TAG_W must equal IVMUL_TAG_W");
   end

   logic       s1_valid;
   logic       s2_valid;
   logic       rr;
   logic       s1_port;
   ivmul_req_t s1_q;
   ivmul_req_t req_sel;
   ivmul_rsp_t s2_q;
   ivmul_rsp_t s2_d;

   logic        s2_load;
   logic        s1_free;
   logic        gnt;
   logic        accept;
   logic [1:0]  ready;
   logic [31:0] mul_res;

   assign s2_load = !s2_valid || bus.rsp_ready_i;
   assign s1_free = !s1_valid || s2_load;

   // A lone requester wins; on contention rr decides.
   always_comb begin
      gnt = rr;
      unique case (1'b1)
         bus.req_valid_i == 2'b01: gnt = 1'b0;
         bus.req_valid_i == 2'b10: gnt = 1'b1;
         default:                  gnt = rr;
      endcase
   end

   always_comb begin
      ready = 2'b00;
      if (s1_free && !flush_i) begin
         ready = bus.req_valid_i & (gnt ? 2'b10 : 2'b01);
      end
   end

   assign accept          = |ready;
   assign bus.req_ready_o = ready;

   assign req_sel.a   = bus.req_a_i[gnt];
   assign req_sel.b   = bus.req_b_i[gnt];
   assign req_sel.opc = bus.req_opc_i[gnt];
   assign req_sel.tag = bus.req_tag_i[gnt];

   ivmul u_mul (
      .a      (s1_q.a),
      .b      (s1_q.b),
      .opc    (s1_q.opc),
      .result (mul_res)
   );

   // Illegal ops must leave a clean zero, not the raw product.
   assign s2_d.illegal = (s1_q.opc == IVMUL_ILL);
   assign s2_d.result  = s2_d.illegal ? 32'h0 : mul_res;
   assign s2_d.port    = s1_port;
   assign s2_d.tag     = s1_q.tag;

   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         rr       <= 1'b0;
      end else if (flush_i) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_load) s2_valid <= s1_valid;
         if (s1_free) s1_valid <= accept;
         if (accept)  rr       <= ~gnt;
      end
   end

   // Payload only; validity lives in the reset block above.
   always_ff @(posedge core_clock_i) begin
      if (accept) begin
         s1_q    <= req_sel;
         s1_port <= gnt;
      end
      if (s2_load) s2_q <= s2_d;
   end

   assign bus.rsp_valid_o   = s2_valid;
   assign bus.rsp_result_o  = s2_q.result;
   assign bus.rsp_port_o    = s2_q.port;
   assign bus.rsp_tag_o     = s2_q.tag;
   assign bus.rsp_illegal_o = s2_valid & s2_q.illegal;

endmodule

// File: tb/tb_ivmul_arbiter.sv
// tb_ivmul_arbiter: directed vector table plus hand-written
// contention, backpressure, flush and async reset sequences.
module tb_ivmul_arbiter;
   import ivmul_pkg::*;

   localparam int TAG_W = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic flush = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   ivmul_arbiter_if #(.TAG_W(TAG_W)) bus ();

   ivmul_arbiter #(.TAG_W(TAG_W)) dut (
      .core_clock_i   (clk),
      .core_reset_n_i (rst_n),
      .flush_i        (flush),
      .bus            (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        port;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  opc;
      logic [5:0]  tag;
      logic [31:0] res;
      logic        ill;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic idle;
      bus.req_valid_i = 2'b00;
      flush           = 1'b0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic p, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] opc,
                        input logic [5:0] tag);
      bus.req_a_i[p]     = a;
      bus.req_b_i[p]     = b;
      bus.req_opc_i[p]   = opc;
      bus.req_tag_i[p]   = tag;
      bus.req_valid_i[p] = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] q [$];
      logic [5:0] nt;
      logic [5:0] e;
      int acc, rcv, sent, got;

      vecs[0] = '{1'b0, 32'h0003_FFFE, 32'h0004_0005, IVMUL_LO,
                  6'd5, 32'h000C_FFF6, 1'b0};
      vecs[1] = '{1'b1, 32'h7FFF_8000, 32'h7FFF_8000, IVMUL_HI,
                  6'd11, 32'h3FFF_4000, 1'b0};
      vecs[2] = '{1'b1, 32'h7FFF_8000, 32'h7FFF_8000, IVMUL_DOT,
                  6'd12, 32'h7FFF_0001, 1'b0};
      vecs[3] = '{1'b1, 32'h7FFF_8000, 32'h7FFF_8000, IVMUL_ILL,
                  6'd13, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b0, 32'h7FFF_8000, 32'h7FFF_8000, IVMUL_LO,
                  6'd14, 32'h0001_0000, 1'b0};
      vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, IVMUL_DOT,
                  6'd15, 32'h0000_0002, 1'b0};
      vecs[6] = '{1'b1, 32'h8000_8000, 32'h0001_FFFF, IVMUL_HI,
                  6'd16, 32'hFFFF_0000, 1'b0};
      vecs[7] = '{1'b0, 32'h8000_8000, 32'h0001_FFFF, IVMUL_LO,
                  6'd17, 32'h8000_8000, 1'b0};
      vecs[8] = '{1'b1, 32'h8000_8000, 32'h0001_FFFF, IVMUL_DOT,
                  6'd63, 32'h0000_0000, 1'b0};

      bus.req_valid_i = 2'b00;
      bus.req_a_i     = '0;
      bus.req_b_i     = '0;
      bus.req_opc_i   = '0;
      bus.req_tag_i   = '0;
      bus.rsp_ready_i = 1'b1;

      // Reset state
      #1;
      drive(1'b0, 32'h0, 32'h0, IVMUL_LO, 6'd0);
      do_reset;
      settle;
      chk("rst_ready", 32'(bus.req_ready_o), 32'h1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
      chk("rst_illegal", 32'(bus.rsp_illegal_o), 32'h0);
      idle;
      tick;

      // Vector table: single op, 2 cycles to response
      foreach (vecs[i]) begin
         bus.rsp_ready_i = 1'b1;
         drive(vecs[i].port, vecs[i].a, vecs[i].b,
               vecs[i].opc, vecs[i].tag);
         settle;
         chk("vec_ready", 32'(bus.req_ready_o),
             vecs[i].port ? 32'h2 : 32'h1);
         tick;
         idle;
         settle;
         chk("vec_early", 32'(bus.rsp_valid_o), 32'h0);
         tick;
         chk("vec_valid", 32'(bus.rsp_valid_o), 32'h1);
         chk("vec_result", bus.rsp_result_o, vecs[i].res);
         chk("vec_port", 32'(bus.rsp_port_o), 32'(vecs[i].port));
         chk("vec_tag", 32'(bus.rsp_tag_o), 32'(vecs[i].tag));
         chk("vec_illegal", 32'(bus.rsp_illegal_o), 32'(vecs[i].ill));
         tick;
      end

      // Contention: both valid from reset
      idle;
      drive(1'b0, 32'h0002_0003, 32'h0005_0007, IVMUL_DOT, 6'd10);
      drive(1'b1, 32'h0001_0001, 32'hFFFF_FFFF, IVMUL_LO, 6'd20);
      bus.rsp_ready_i = 1'b1;
      do_reset;
      for (int k = 0; k < 8; k++) begin
         settle;
         chk("cont_ready", 32'(bus.req_ready_o),
             (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("cont_valid", 32'(bus.rsp_valid_o),
             (k >= 2) ? 32'h1 : 32'h0);
         if (k >= 2) begin
            chk("cont_port", 32'(bus.rsp_port_o), 32'(k % 2));
            chk("cont_tag", 32'(bus.rsp_tag_o),
                (k % 2 == 0) ? 32'd10 : 32'd20);
            chk("cont_result", bus.rsp_result_o,
                (k % 2 == 0) ? 32'd31 : 32'hFFFF_FFFF);
         end
         tick;
      end

      // Backpressure: port 0 streaming, writeback stalled
      idle;
      do_reset;
      bus.rsp_ready_i = 1'b0;
      nt  = 6'd0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 32'(nt), 32'h2, IVMUL_LO, nt);
         settle;
         if (bus.req_ready_o[0]) begin
            q.push_back(nt);
            nt++;
            acc++;
         end
         if (c >= 2) begin
            chk("bp_hold_valid", 32'(bus.rsp_valid_o), 32'h1);
            chk("bp_hold_tag", 32'(bus.rsp_tag_o), 32'(q[0]));
            chk("bp_hold_result", bus.rsp_result_o, 32'(q[0]) * 2);
         end
         tick;
      end
      chk("bp_accepts", 32'(acc), 32'd2);
      settle;
      chk("bp_ready_low", 32'(bus.req_ready_o), 32'h0);

      bus.rsp_ready_i = 1'b1;
      sent = acc;
      rcv  = 0;
      for (int c = 0; c < 20; c++) begin
         if (sent < 5) drive(1'b0, 32'(nt), 32'h2, IVMUL_LO, nt);
         else bus.req_valid_i = 2'b00;
         settle;
         if (c == 0)
            chk("bp_release_accept", 32'(bus.req_ready_o), 32'h1);
         if (bus.rsp_valid_o) begin
            if (q.size() == 0) begin
               chk("bp_extra_rsp", 32'(bus.rsp_tag_o), 32'h0);
               chk("bp_extra_cnt", 32'h1, 32'(q.size()));
            end else begin
               e = q.pop_front();
               chk("bp_drain_tag", 32'(bus.rsp_tag_o), 32'(e));
               chk("bp_drain_res", bus.rsp_result_o, 32'(e) * 2);
               rcv++;
            end
         end
         if (bus.req_ready_o[0]) begin
            q.push_back(nt);
            nt++;
            sent++;
         end
         tick;
         if (sent >= 5 && q.size() == 0) break;
      end
      chk("bp_rcv_count", 32'(rcv), 32'd5);
      chk("bp_queue_empty", 32'(q.size()), 32'd0);

      // Flush with S1 and S2 both valid
      idle;
      do_reset;
      bus.rsp_ready_i = 1'b0;
      drive(1'b0, 32'h1, 32'h1, IVMUL_LO, 6'd40);
      tick;
      drive(1'b0, 32'h1, 32'h1, IVMUL_LO, 6'd41);
      tick;
      bus.req_valid_i = 2'b00;
      settle;
      chk("fl_pre_valid", 32'(bus.rsp_valid_o), 32'h1);
      chk("fl_pre_tag", 32'(bus.rsp_tag_o), 32'd40);
      flush = 1'b1;
      drive(1'b1, 32'h1, 32'h1, IVMUL_LO, 6'd50);
      settle;
      chk("fl_no_accept", 32'(bus.req_ready_o), 32'h0);
      tick;
      idle;
      settle;
      chk("fl_rsp_drop", 32'(bus.rsp_valid_o), 32'h0);
      bus.rsp_ready_i = 1'b1;
      got = 0;
      for (int c = 0; c < 5; c++) begin
         settle;
         if (bus.rsp_valid_o) got++;
         tick;
      end
      chk("fl_no_rsp", 32'(got), 32'd0);

      // Async reset mid-stream, rr left pointing at port 1
      idle;
      do_reset;
      bus.rsp_ready_i = 1'b1;
      drive(1'b0, 32'h1, 32'h1, IVMUL_LO, 6'd1);
      drive(1'b1, 32'h1, 32'h1, IVMUL_LO, 6'd2);
      tick;
      tick;
      tick;
      settle;
      chk("ar_pre_valid", 32'(bus.rsp_valid_o), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid_drop", 32'(bus.rsp_valid_o), 32'h0);
      tick;
      tick;
      rst_n = 1'b1;
      settle;
      chk("ar_first_gnt", 32'(bus.req_ready_o), 32'h1);
      tick;
      chk("ar_second_gnt", 32'(bus.req_ready_o), 32'h2);
      idle;
      tick;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ivmul_arbiter.md
# ivmul_arbiter

Shares one packed 16×16 SIMD multiplier between two issue ports (ALU pipe 0 and pipe 1) with round-robin arbitration. Two-stage pipelined wrapper: grant and operand register in stage 1, multiplier output register in stage 2. Results carry the requester's ID and tag back to writeback over a valid/ready channel with full backpressure. A pipeline flush kills every operation in flight.

## Interface
- `TAG_W`, 6: width of the ROB/destination tag carried with each op.
- `core_clock_i`  in  1  single clock; all state on rising edge.
- `core_reset_n_i`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  kill all in-flight ops; no accept this cycle.
- `req_valid_i[1:0]`  in  2  per-port request valid.
- `req_ready_o[1:0]`  out  2  per-port accept; a transfer happens when valid and ready are both high.
- `req_a_i[1:0]`, `req_b_i[1:0]`  in  2×32  operands.
- `req_opc_i[1:0]`  in  2×2  00 = low halves, 01 = high halves, 10 = dot-accumulate, 11 = illegal.
- `req_tag_i[1:0]`  in  2×TAG_W  tag.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  writeback accept.
- `rsp_result_o`  out  32  result.
- `rsp_port_o`  out  1  originating port.
- `rsp_tag_o`  out  TAG_W  originating tag.
- `rsp_illegal_o`  out  1  op had opc 11; `rsp_result_o` is 0 for these.

## Operation
- Pipeline: S1 holds {valid, a, b, opc, port, tag}. S2 holds {valid, result, port, tag, illegal}.
- S2 loads from S1 when `!s2_valid || rsp_ready_i`.
- S1 is free when `!s1_valid`, or when S1 moves into S2 this cycle.
- Arbitration: round-robin pointer `rr` names the preferred port.
  - If both ports are valid, `rr` wins. If one is valid, that one wins.
  - At most one `req_ready_o` bit is high per cycle. Ready requires S1 free and `!flush_i`.
  - Ready is computed from valid; the loser sees ready = 0.
- After every accepted transfer, `rr` becomes the non-granted port. If nothing is accepted, `rr` holds.
- Multiplier (combinational, between S1 and S2):
  - `p0 = signed(a[15:0]) * signed(b[15:0])`
  - `p1 = signed(a[31:16]) * signed(b[31:16])`, each 32 bits.
  - opc 00 → {p1[15:0], p0[15:0]}
  - opc 01 → {p1[31:16], p0[31:16]}
  - opc 10 → p0 + p1, mod 2^32
  - opc 11 → 0, with illegal = 1. Never X.
- Flush: `flush_i` clears `s1_valid` and `s2_valid` at the next edge. It overrides any load in that cycle, and `rsp_valid_o` drops the following cycle. `rr` is unchanged.
- Reset values: `s1_valid` = 0, `s2_valid` = 0, `rr` = 0. Data registers need no reset.
  - Outputs after reset: `rsp_valid_o` = 0, `req_ready_o` = 2'b01 if only port 0 is valid (combinational), `rsp_illegal_o` = 0.
  - Reset mid-operation discards all ops.

## Timing
- Latency: a request accepted at edge N appears on `rsp_*` after edge N+1. That is 2 cycles from the handshake to the response cycle.
- Throughput: 1 op/cycle sustained when `rsp_ready_i` = 1.
- Backpressure:
  - With `rsp_ready_i` = 0, S2 holds and S1 holds.
  - Up to 2 ops are buffered, then `req_ready_o` = 0.
  - On the first cycle `rsp_ready_i` returns to 1, S2 drains, S1 advances, and a new request is accepted in the same cycle.
- Response stability: while `rsp_valid_o` = 1 and `rsp_ready_i` = 0, all `rsp_*` outputs stay stable.
- Flush concurrent with `rsp_ready_i` = 1: the S2 op counts as consumed by the handshake, and all state is cleared.
- Requesters may drop valid without a handshake. The arbiter keeps no grant lock.

## Structure
- Shared package `ivmul_pkg`:
  - opcode localparams `IVMUL_LO` = 2'b00, `IVMUL_HI` = 2'b01, `IVMUL_DOT` = 2'b10.
  - packed structs `ivmul_req_t` {a, b, opc, tag} and `ivmul_rsp_t` {result, port, tag, illegal}, parameterised via `TAG_W` in the instantiating module.
- One sub-module: the existing combinational `ivmul` datapath, instantiated between S1 and S2. Its 11 case is masked by the wrapper so that 0 is driven.
- Arbiter is in-line logic, not a separate module.

## Test plan
- Single op, no backpressure:
  - Port 0 sends a = 0x0003_FFFE, b = 0x0004_0005, opc 00, tag 5.
  - Response 2 cycles later: result 0x000C_FFF6, port 0, tag 5.
- Opcode coverage on port 1 with a = 0x7FFF_8000, b = 0x7FFF_8000:
  - opc 01 → 0x3FFF_4000.
  - opc 10 → 0x7FFF_0001.
  - opc 11 → result 0, illegal = 1.
- Contention: both ports valid continuously from reset, `rsp_ready_i` = 1.
  - Grants alternate 0, 1, 0, 1.
  - Responses arrive in grant order at 1/cycle.
- Backpressure:
  - Hold `rsp_ready_i` = 0 for 5 cycles with port 0 streaming.
  - Exactly 2 accepts occur, then `req_ready_o` = 0.
  - The held `rsp_*` stay stable.
  - On release, ops drain in order with no loss or duplication.
- Flush: assert `flush_i` with S1 and S2 both valid.
  - Next cycle `rsp_valid_o` = 0 and no response ever arrives for those tags.
  - A request made during the flush cycle is not accepted.
- Async reset: assert `core_reset_n_i` mid-stream, between clock edges.
  - `rsp_valid_o` = 0 immediately.
  - After release, `rr` = 0: with both ports valid, the first grant goes to port 0.
